// File: rtl/bird_pkg.sv
// Shared types for the bird motion controller: game states and motion-mode encodings.
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int unsigned MODE_HOLD = 0;
  localparam int unsigned MODE_FLAP = 1;

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchroniser for an active-low button plus a registered falling-edge pulse.
module button_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic fall
);

  logic meta;
  logic level_d;

  // Released state is 1, so reset never fabricates a press edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta    <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      fall    <= 1'b0;
    end else begin
      meta    <= btn_n;
      level   <= meta;
      level_d <= level;
      fall    <= level_d & ~level;
    end
  end

endmodule

// File: rtl/bird_motion_ctrl.sv
// Tick-paced vertical motion for the flappy-bird game: hold or flap/gravity model,
// floor/crash death and IDLE/FLY/DEAD sequencing, with registered row outputs.
module bird_motion_ctrl
  import bird_pkg::*;
#(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned TICK_CYCLES  = 2500000,
  parameter int unsigned START_ROW    = 3,
  parameter int unsigned MODE         = 1,
  parameter int unsigned FLAP_VEL     = 2,
  parameter int unsigned MAX_FALL     = 2,
  parameter int unsigned DIE_ON_FLOOR = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     flap_n,
  input  logic                     crash,
  output logic [$clog2(ROWS)-1:0]  bird_pos,
  output logic [ROWS-1:0]          bird_row,
  output logic                     tick,
  output logic                     ceiling,
  output logic                     dead
);

  localparam int unsigned POS_W = $clog2(ROWS);
  localparam int unsigned CNT_W = $clog2(TICK_CYCLES);
  localparam int unsigned VMAG  = (FLAP_VEL > MAX_FALL) ? FLAP_VEL : MAX_FALL;
  localparam int unsigned VEL_W = $clog2(VMAG + 1) + 1;
  localparam int unsigned SUM_W = (((POS_W + 1) > VEL_W) ? (POS_W + 1) : VEL_W) + 1;

  localparam logic [POS_W-1:0]        START_POS = POS_W'(START_ROW);
  localparam logic [POS_W-1:0]        TOP_POS   = POS_W'(ROWS - 1);
  localparam logic [ROWS-1:0]         START_OH  = ROWS'(1) << START_ROW;
  localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(TICK_CYCLES - 1);
  localparam logic signed [VEL_W-1:0] VEL_FLAP  = VEL_W'(FLAP_VEL);
  localparam logic signed [VEL_W-1:0] VEL_MIN   = VEL_W'(0 - MAX_FALL);
  localparam logic signed [VEL_W-1:0] VEL_ONE   = VEL_W'(1);
  localparam logic signed [SUM_W-1:0] SUM_TOP   = SUM_W'(ROWS - 1);

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [VEL_W-1:0]   vel_q, vel_d;
  logic                      req_q, req_d;
  logic [POS_W-1:0]          pos_d;
  logic                      tick_d;

  logic                      btn_level;
  logic                      flap_edge;
  logic                      tick_evt;
  logic signed [VEL_W-1:0]   vel_dec;
  logic signed [VEL_W-1:0]   mot_vel;
  logic signed [SUM_W-1:0]   sum;
  logic [POS_W-1:0]          mot_pos;

  button_edge_sync u_flap_sync (
    .clock (clock),
    .reset (reset),
    .btn_n (flap_n),
    .level (btn_level),
    .fall  (flap_edge)
  );

  assign tick_evt = (state_q == FLY) && (cnt_q == CNT_LAST);

  // Candidate position/velocity for the next tick.
  always_comb begin
    vel_dec = vel_q - VEL_ONE;
    mot_vel = '0;
    mot_pos = bird_pos;
    sum     = '0;
    if (MODE == MODE_FLAP) begin
      if (req_q || flap_edge)   mot_vel = VEL_FLAP;
      else if (vel_dec < VEL_MIN) mot_vel = VEL_MIN;
      else                        mot_vel = vel_dec;
      sum = SUM_W'(signed'({1'b0, bird_pos})) + SUM_W'(mot_vel);
      if (sum[SUM_W-1]) begin
        mot_pos = '0;
      end else if (sum > SUM_TOP) begin
        mot_pos = TOP_POS;
        mot_vel = '0;
      end else begin
        mot_pos = sum[POS_W-1:0];
      end
    end else begin
      if (!btn_level) mot_pos = (bird_pos == TOP_POS) ? bird_pos : bird_pos + POS_W'(1);
      else            mot_pos = (bird_pos == '0) ? bird_pos : bird_pos - POS_W'(1);
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    vel_d   = vel_q;
    req_d   = req_q;
    pos_d   = bird_pos;
    tick_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        pos_d = START_POS;
        vel_d = '0;
        req_d = 1'b0;
        if (enable && flap_edge) state_d = FLY;
      end
      FLY: begin
        if (!enable) begin
          state_d = IDLE;
          pos_d   = START_POS;
          vel_d   = '0;
          req_d   = 1'b0;
        end else if (crash) begin
          state_d = DEAD;
          req_d   = 1'b0;
        end else begin
          cnt_d = tick_evt ? '0 : cnt_q + CNT_W'(1);
          if ((MODE == MODE_FLAP) && flap_edge) req_d = 1'b1;
          if (tick_evt) begin
            pos_d  = mot_pos;
            vel_d  = mot_vel;
            req_d  = 1'b0;
            tick_d = 1'b1;
            if ((DIE_ON_FLOOR != 0) && (mot_pos == '0)) state_d = DEAD;
          end
        end
      end
      DEAD: begin
        if (!enable) begin
          state_d = IDLE;
          pos_d   = START_POS;
          vel_d   = '0;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        pos_d   = START_POS;
        vel_d   = '0;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      vel_q    <= '0;
      req_q    <= 1'b0;
      bird_pos <= START_POS;
      bird_row <= START_OH;
      ceiling  <= (START_POS == TOP_POS);
      dead     <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vel_q    <= vel_d;
      req_q    <= req_d;
      bird_pos <= pos_d;
      bird_row <= ROWS'(1) << pos_d;
      ceiling  <= (pos_d == TOP_POS);
      dead     <= (state_d == DEAD);
      tick     <= tick_d;
    end
  end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench: flap-mode and hold-mode controllers with a 4-cycle tick.
module tb_bird_motion_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable_f, flap_n_f, crash_f;
  logic       enable_h, flap_n_h, crash_h;
  logic [2:0] pos_f, pos_h;
  logic [7:0] row_f, row_h;
  logic       tick_f, tick_h, ceil_f, ceil_h, dead_f, dead_h;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bird_motion_ctrl #(
    .ROWS(8), .TICK_CYCLES(4), .START_ROW(3), .MODE(1),
    .FLAP_VEL(2), .MAX_FALL(2), .DIE_ON_FLOOR(1)
  ) u_flap (
    .clock(clock), .reset(reset), .enable(enable_f), .flap_n(flap_n_f), .crash(crash_f),
    .bird_pos(pos_f), .bird_row(row_f), .tick(tick_f), .ceiling(ceil_f), .dead(dead_f)
  );

  bird_motion_ctrl #(
    .ROWS(8), .TICK_CYCLES(4), .START_ROW(3), .MODE(0),
    .FLAP_VEL(2), .MAX_FALL(2), .DIE_ON_FLOOR(0)
  ) u_hold (
    .clock(clock), .reset(reset), .enable(enable_h), .flap_n(flap_n_h), .crash(crash_h),
    .bird_pos(pos_h), .bird_row(row_h), .tick(tick_h), .ceiling(ceil_h), .dead(dead_h)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Press two cycles, release; edge reaches the FSM on the fourth edge.
  task automatic press_f();
    flap_n_f = 1'b0; step(); step(); flap_n_f = 1'b1;
  endtask

  task automatic start_f();
    press_f(); step(); step();
  endtask

  task automatic wait_tick_f(output int n);
    n = 0;
    do begin step(); n++; end while (!tick_f && n < 16);
    chk("tick_f_seen", 32'(tick_f), 1);
  endtask

  task automatic wait_tick_h(output int n);
    n = 0;
    do begin step(); n++; end while (!tick_h && n < 16);
    chk("tick_h_seen", 32'(tick_h), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_fall[6];
    int exp_flap[3];
    int exp_hold_up[3];
    int exp_hold_dn[8];
    exp_fall    = '{6, 6, 5, 3, 1, 0};
    exp_flap    = '{5, 7, 7};
    exp_hold_up = '{4, 5, 6};
    exp_hold_dn = '{5, 4, 3, 2, 1, 0, 0, 0};

    reset = 1'b1;
    enable_f = 1'b0; flap_n_f = 1'b1; crash_f = 1'b0;
    enable_h = 1'b0; flap_n_h = 1'b1; crash_h = 1'b0;
    repeat (3) step();
    chk("rst_pos", 32'(pos_f), 3);
    chk("rst_row", 32'(row_f), 32'h08);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_tick_f", 32'(tick_f), 0);
      chk("idle_tick_h", 32'(tick_h), 0);
    end
    chk("idle_pos", 32'(pos_f), 3);
    chk("idle_row", 32'(row_f), 32'h08);
    chk("idle_dead", 32'(dead_f), 0);
    chk("idle_ceil", 32'(ceil_f), 0);
    chk("idle_pos_h", 32'(pos_h), 3);

    // Flap mode: single flap then free fall into the floor.
    enable_f = 1'b1;
    start_f();
    press_f();
    wait_tick_f(n);
    chk("fall_gap0", 32'(n), 2);
    chk("fall_pos0", 32'(pos_f), 5);
    chk("fall_row0", 32'(row_f), 32'h20);
    for (int i = 0; i < 6; i++) begin
      wait_tick_f(n);
      chk("fall_gap", 32'(n), 4);
      chk("fall_pos", 32'(pos_f), 32'(exp_fall[i]));
      chk("fall_dead", 32'(dead_f), (i == 5) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      chk("dead_no_tick", 32'(tick_f), 0);
    end
    chk("dead_pos", 32'(pos_f), 0);
    chk("dead_hold", 32'(dead_f), 1);
    enable_f = 1'b0;
    step();
    chk("dead_exit_pos", 32'(pos_f), 3);
    chk("dead_exit_dead", 32'(dead_f), 0);

    // Flap every tick: hits the ceiling and velocity clears there.
    enable_f = 1'b1;
    start_f();
    for (int i = 0; i < 3; i++) begin
      press_f();
      wait_tick_f(n);
      chk("ceil_gap", 32'(n), 2);
      chk("ceil_pos", 32'(pos_f), 32'(exp_flap[i]));
      chk("ceil_flag", 32'(ceil_f), (i > 0) ? 1 : 0);
    end
    wait_tick_f(n);
    chk("ceil_vel0_pos", 32'(pos_f), 6);
    chk("ceil_vel0_flag", 32'(ceil_f), 0);
    enable_f = 1'b0;
    step();
    chk("ceil_exit_pos", 32'(pos_f), 3);

    // Crash coincident with a tick event at row 5.
    enable_f = 1'b1;
    start_f();
    press_f();
    wait_tick_f(n);
    chk("crash_pre_pos", 32'(pos_f), 5);
    repeat (3) step();
    crash_f = 1'b1;
    step();
    crash_f = 1'b0;
    chk("crash_tick", 32'(tick_f), 0);
    chk("crash_pos", 32'(pos_f), 5);
    chk("crash_dead", 32'(dead_f), 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("crash_hold_pos", 32'(pos_f), 5);
    end
    enable_f = 1'b0;
    step();
    chk("crash_idle_pos", 32'(pos_f), 3);
    chk("crash_idle_dead", 32'(dead_f), 0);
    chk("crash_idle_row", 32'(row_f), 32'h08);

    // Reset mid-flight at row 6 with a flap request pending.
    enable_f = 1'b1;
    start_f();
    press_f();
    wait_tick_f(n);
    chk("rmid_pos5", 32'(pos_f), 5);
    wait_tick_f(n);
    chk("rmid_pos6", 32'(pos_f), 6);
    repeat (3) step();
    flap_n_f = 1'b0;
    step();
    chk("rmid_tick", 32'(tick_f), 1);
    chk("rmid_pos6b", 32'(pos_f), 6);
    step();
    flap_n_f = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    chk("rmid_rst_pos", 32'(pos_f), 3);
    chk("rmid_rst_tick", 32'(tick_f), 0);
    chk("rmid_rst_dead", 32'(dead_f), 0);
    chk("rmid_rst_row", 32'(row_f), 32'h08);
    reset = 1'b0;
    step();
    chk("rmid_idle_pos", 32'(pos_f), 3);
    start_f();
    wait_tick_f(n);
    chk("rmid_gap", 32'(n), 4);
    chk("rmid_noflap_pos", 32'(pos_f), 2);
    enable_f = 1'b0;
    step();

    // Hold mode: rise while held, fall after release, saturate at the floor.
    enable_h = 1'b1;
    flap_n_h = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      wait_tick_h(n);
      chk("hold_up_gap", 32'(n), 4);
      chk("hold_up_pos", 32'(pos_h), 32'(exp_hold_up[i]));
    end
    flap_n_h = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_tick_h(n);
      chk("hold_dn_pos", 32'(pos_h), 32'(exp_hold_dn[i]));
      chk("hold_dn_dead", 32'(dead_h), 0);
    end
    chk("hold_floor_row", 32'(row_h), 32'h01);
    enable_h = 1'b0;
    step();
    chk("hold_exit_pos", 32'(pos_h), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bird_motion_ctrl.md
# bird_motion_ctrl

Parametrised vertical-motion controller for the flappy-bird game: converts the player button into a bird row position on an N-row LED column using a tick-paced gravity/flap model. Supports a legacy hold-to-rise mode and a flap-impulse mode with velocity, plus floor/crash death and game-state sequencing. Sits between the button input and the LED matrix driver and collision logic.

## Interface
- ROWS, 8: number of LED rows; position range 0..ROWS-1 (0 = bottom).
- TICK_CYCLES, 2500000: clock cycles per motion tick (≥2).
- START_ROW, 3: row loaded on reset, IDLE and restart.
- MODE, 1: 0 = hold (button low rises 1 row/tick, else falls 1 row/tick); 1 = flap (impulse + gravity).
- FLAP_VEL, 2: velocity loaded on a flap (MODE 1), rows/tick.
- MAX_FALL, 2: maximum downward speed magnitude (MODE 1).
- DIE_ON_FLOOR, 1: 1 = reaching row 0 while flying ends the game.

- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  game run; low forces IDLE.
- flap_n  in  1  player button, active-low, asynchronous.
- crash  in  1  collision pulse from pipe logic.
- bird_pos  out  $clog2(ROWS)  current row.
- bird_row  out  ROWS  one-hot of bird_pos.
- tick  out  1  one-cycle pulse per motion update.
- ceiling  out  1  bird_pos == ROWS-1.
- dead  out  1  high in DEAD state.

## Operation
- Button path: 2-flop synchroniser, falling-edge detector → flap_edge. In MODE 1, flap_edge sets sticky flap_req, cleared on the tick that consumes it.
- Tick counter runs only in FLY: 0..TICK_CYCLES-1, wraps to 0; terminal count = internal tick event. Held 0 in IDLE/DEAD.
- States: IDLE, FLY, DEAD.
  - IDLE: pos=START_ROW, vel=0. flap_edge with enable=1 → FLY (that edge is not a flap request).
  - FLY, on tick event: MODE 0: synced flap_n==0 → pos+1, else pos-1, saturating 0/ROWS-1. MODE 1: vel_next = FLAP_VEL if (flap_req or flap_edge this cycle) else max(vel-1, -MAX_FALL); pos_next = clamp(pos+vel_next, 0, ROWS-1); if clamped at top, vel=0.
  - FLY → DEAD: crash=1 (any cycle; pos frozen, tick event ignored if coincident), or DIE_ON_FLOOR=1 and pos_next==0 on a tick.
  - FLY or DEAD with enable=0 → IDLE. DEAD holds pos until then.
- Arithmetic: vel signed, width fits ±max(FLAP_VEL,MAX_FALL); pos+vel computed one bit wider, signed, then clamped.

## Timing
- Reset values: bird_pos=START_ROW, bird_row=one-hot START_ROW, tick=0, ceiling=(START_ROW==ROWS-1), dead=0, state IDLE, counter 0, vel 0, flap_req 0.
- flap_n fall → flap_edge: 3 clock edges (2 sync + edge register).
- bird_pos, bird_row, ceiling, tick all registered on the same edge; tick is high in the first cycle the new pos is visible.
- First tick: TICK_CYCLES cycles after entering FLY.
- crash → dead high next cycle. enable low → IDLE next cycle, outputs to reset values except counter-independent sync flops.
- reset mid-FLY: all state returns to reset values on that edge; in-flight flap_req dropped.

## Structure
- Package bird_pkg: state enum (IDLE, FLY, DEAD), MODE encodings (MODE_HOLD=0, MODE_FLAP=1).
- Sub-module button_edge_sync: synchroniser + falling-edge detector, reused by other button inputs.
- Main module: counter, FSM, motion datapath, one-hot decode.

## Test plan
(TICK_CYCLES=4, ROWS=8, START_ROW=3 unless stated)
- Reset held 3 cycles then 20 idle cycles → bird_pos=3, bird_row=8'b00001000, tick never high, dead=0.
- MODE 1: press to start, one flap before first tick, no more presses → pos per tick 5,6,6,5,3,1 then clamp 0 → dead=1 same edge pos=0, tick pulses every 4 cycles.
- MODE 1: flap every tick → pos 5,7,7 with ceiling=1 from pos 7, vel=0 at clamp.
- MODE 0: flap_n low 3 ticks then high → pos 4,5,6 then 5,4,...; DIE_ON_FLOOR=0 → pos saturates at 0, dead stays 0.
- crash asserted in same cycle as tick event at pos 5 → pos stays 5, dead=1 next cycle; enable low → IDLE, pos=3, dead=0.
- reset asserted mid-FLY at pos 6 → next edge pos=3, tick=0, state IDLE; pending flap request not applied after release.
